// File: rtl/picoblaze_intc.sv
// Interrupt controller for KCPSM6: up to 8 level/edge sources merged onto one
// interrupt line, with status, mask, vector and software-force registers on the port bus.
module picoblaze_intc #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h80,
    parameter logic [7:0]  EDGE_MASK   = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_sys,
    input  logic               reset_sys_n,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               interrupt_ack,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               interrupt
);

    localparam logic [7:0] CH_MASK    = 8'((16'd1 << NUM_IRQ) - 16'd1);
    localparam logic [7:0] EDGE_CH    = EDGE_MASK & CH_MASK;
    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_MASK   = 2'd1;
    localparam logic [1:0] OFF_VECTOR = 2'd2;
    localparam logic [1:0] OFF_FORCE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest-numbered requesting channel wins; 8'hFF when nothing requests.
    function automatic logic [7:0] f_vector(input logic [7:0] req);
        logic [7:0] v;
        v = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                v = 8'(i);
            end
        end
        return v;
    endfunction

    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_prev;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    state_t     r_state;

    logic [7:0] w_irq_ext;
    logic [7:0] w_sync;
    logic [7:0] w_hw_set;
    logic       w_in_range;
    logic       w_wr;
    logic       w_wr_status;
    logic       w_wr_mask;
    logic       w_wr_force;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_pending_nxt;
    logic [7:0] w_req;
    logic       w_active;
    logic [7:0] w_rd_mux;
    logic       w_unused;

    assign w_unused   = read_strobe;
    assign w_irq_ext  = 8'(irq_in);
    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_hw_set   = ((EDGE_CH & w_sync & ~r_prev) | (~EDGE_CH & w_sync)) & CH_MASK;
    assign w_in_range = (port_id[7:2] == BASE_ADDR[7:2]);
    assign w_wr       = write_strobe & w_in_range;
    assign w_wr_status = w_wr & (port_id[1:0] == OFF_STATUS);
    assign w_wr_mask   = w_wr & (port_id[1:0] == OFF_MASK);
    assign w_wr_force  = w_wr & (port_id[1:0] == OFF_FORCE);
    assign w_req      = r_pending & r_mask;
    assign w_active   = |w_req;

    // Set/clear sources for pending; set is applied after clear so it wins.
    always_comb begin
        w_set = w_hw_set;
        w_clr = 8'h00;
        if (w_wr_force) begin
            w_set = w_hw_set | out_port;
        end else begin
            w_set = w_hw_set;
        end
        if (w_wr_status) begin
            w_clr = out_port;
        end else begin
            w_clr = 8'h00;
        end
        w_pending_nxt = ((r_pending & ~w_clr) | w_set) & CH_MASK;
    end

    // Read-data mux for the addressed register.
    always_comb begin
        w_rd_mux = 8'h00;
        case (port_id[1:0])
            OFF_STATUS: w_rd_mux = r_pending;
            OFF_MASK:   w_rd_mux = r_mask;
            OFF_VECTOR: w_rd_mux = f_vector(w_req);
            OFF_FORCE:  w_rd_mux = 8'h00;
            default:    w_rd_mux = 8'h00;
        endcase
    end

    // Input synchroniser chain and edge-detect history.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
            r_prev <= 8'h00;
        end else begin
            r_sync[0] <= w_irq_ext & CH_MASK;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    // Pending and mask registers.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            r_pending <= 8'h00;
            r_mask    <= 8'h00;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr_mask) begin
                r_mask <= out_port & CH_MASK;
            end
        end
    end

    // Registered port-bus read path, driven every cycle for the in_port OR-mux.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            rd_data <= 8'h00;
            rd_hit  <= 1'b0;
        end else begin
            rd_hit  <= w_in_range;
            rd_data <= w_in_range ? w_rd_mux : 8'h00;
        end
    end

    // Request FSM; interrupt is registered alongside the next state.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            r_state   <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_active) begin
                        r_state   <= ST_REQ;
                        interrupt <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        interrupt <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (interrupt_ack) begin
                        r_state   <= ST_SERVICE;
                        interrupt <= 1'b0;
                    end else if (!w_active) begin
                        r_state   <= ST_IDLE;
                        interrupt <= 1'b0;
                    end else begin
                        r_state   <= ST_REQ;
                        interrupt <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    // Only end-of-interrupt releases service; acks here are ignored.
                    if (w_wr_status) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SERVICE;
                    end
                    interrupt <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picoblaze_intc.sv
// Scoreboard bench for picoblaze_intc: register reads are queued with their
// expected value when issued and compared when rd_data/rd_hit are produced.
module tb_picoblaze_intc;

    localparam logic [7:0] BASE = 8'h80;
    localparam int         SYNC = 2;

    logic       clk_sys = 1'b0;
    logic       reset_sys_n;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] irq_in;
    logic       interrupt_ack;
    logic [7:0] rd_data;
    logic       rd_hit;
    logic       interrupt;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] q_exp [$];

    picoblaze_intc #(
        .NUM_IRQ    (8),
        .BASE_ADDR  (BASE),
        .EDGE_MASK  (8'h03),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_sys_n  (reset_sys_n),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .irq_in       (irq_in),
        .interrupt_ack(interrupt_ack),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .interrupt    (interrupt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] data);
        port_id      = BASE + {6'd0, off};
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic exp_hit,
                      input logic [7:0] exp_data);
        logic [8:0] e;
        port_id     = addr;
        read_strobe = 1'b1;
        q_exp.push_back({exp_hit, exp_data});
        tick();
        read_strobe = 1'b0;
        port_id     = 8'h00;
        e = q_exp.pop_front();
        chk(tag, {rd_hit, rd_data}, e);
    endtask

    task automatic wait_irq(input string tag, input logic exp, input int budget);
        int n;
        n = 0;
        while (interrupt !== exp && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 9'(interrupt), 9'(exp));
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        reset_sys_n   = 1'b0;
        port_id       = 8'h00;
        out_port      = 8'h00;
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        irq_in        = 8'h00;
        interrupt_ack = 1'b0;
        tick();
        tick();
        chk("rst_irq", 9'(interrupt), 9'h000);
        chk("rst_rd", {rd_hit, rd_data}, 9'h000);
        reset_sys_n = 1'b1;
        tick();

        rd("rst_vector", BASE + 8'd2, 1'b1, 8'hFF);
        rd("rst_outside", BASE + 8'd4, 1'b0, 8'h00);
        rd("rst_status", BASE, 1'b1, 8'h00);
        rd("rst_mask", BASE + 8'd1, 1'b1, 8'h00);

        // Edge channel 0: interrupt appears SYNC+2 cycles after irq_in rises.
        wr(2'd1, 8'h01);
        irq_in[0] = 1'b1;
        for (int i = 1; i <= SYNC + 2; i++) begin
            tick();
            if (i == 3) irq_in[0] = 1'b0;
            chk($sformatf("edge_lat%0d", i), 9'(interrupt), (i == SYNC + 2) ? 9'h001 : 9'h000);
        end
        rd("edge_status", BASE, 1'b1, 8'h01);
        rd("edge_vector", BASE + 8'd2, 1'b1, 8'h00);
        chk("edge_hold", 9'(interrupt), 9'h001);
        ack();
        chk("edge_ack", 9'(interrupt), 9'h000);
        wr(2'd0, 8'h01);
        tick();
        tick();
        chk("edge_noreq", 9'(interrupt), 9'h000);
        rd("edge_clr", BASE, 1'b1, 8'h00);

        // Level channel 3 held high through EOI re-requests.
        wr(2'd1, 8'h08);
        irq_in[3] = 1'b1;
        wait_irq("lvl_req", 1'b1, 10);
        ack();
        chk("lvl_ack", 9'(interrupt), 9'h000);
        tick();
        tick();
        chk("lvl_service", 9'(interrupt), 9'h000);
        wr(2'd0, 8'h08);
        chk("lvl_eoi", 9'(interrupt), 9'h000);
        tick();
        chk("lvl_rereq", 9'(interrupt), 9'h001);
        rd("lvl_status", BASE, 1'b1, 8'h08);
        irq_in[3] = 1'b0;
        ack();
        tick();
        tick();
        tick();
        wr(2'd0, 8'h08);
        tick();
        chk("lvl_idle", 9'(interrupt), 9'h000);
        rd("lvl_clr", BASE, 1'b1, 8'h00);

        // Priority encoding of the vector.
        wr(2'd1, 8'hFF);
        wr(2'd3, 8'h24);
        rd("prio_vec2", BASE + 8'd2, 1'b1, 8'h02);
        rd("force_read", BASE + 8'd3, 1'b1, 8'h00);
        wr(2'd0, 8'h04);
        rd("prio_vec5", BASE + 8'd2, 1'b1, 8'h05);
        wr(2'd0, 8'h20);
        tick();
        chk("prio_drop", 9'(interrupt), 9'h000);
        rd("prio_none", BASE + 8'd2, 1'b1, 8'hFF);

        // Masked channel still pends; unmasking raises the request.
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h10);
        tick();
        tick();
        chk("mask_quiet", 9'(interrupt), 9'h000);
        rd("mask_pend", BASE, 1'b1, 8'h10);
        wr(2'd1, 8'h10);
        chk("mask_lat0", 9'(interrupt), 9'h000);
        tick();
        chk("mask_lat1", 9'(interrupt), 9'h001);
        ack();
        wr(2'd0, 8'h10);
        tick();
        chk("mask_done", 9'(interrupt), 9'h000);

        // Force, then clear while a hardware edge lands on the clear cycle.
        wr(2'd1, 8'h02);
        irq_in[1] = 1'b1;
        tick();
        wr(2'd3, 8'h02);
        wr(2'd0, 8'h02);
        rd("set_wins", BASE, 1'b1, 8'h02);
        wait_irq("sim_req", 1'b1, 5);
        ack();
        chk("sim_ack", 9'(interrupt), 9'h000);

        // Reset in SERVICE with a live read path clears outputs immediately.
        port_id = BASE + 8'd1;
        tick();
        reset_sys_n = 1'b0;
        irq_in      = 8'h00;
        #1;
        chk("mid_rst_irq", 9'(interrupt), 9'h000);
        chk("mid_rst_rd", {rd_hit, rd_data}, 9'h000);
        port_id = 8'h00;
        tick();
        reset_sys_n = 1'b1;
        tick();
        rd("post_rst_status", BASE, 1'b1, 8'h00);
        rd("post_rst_mask", BASE + 8'd1, 1'b1, 8'h00);
        rd("post_rst_vector", BASE + 8'd2, 1'b1, 8'hFF);
        chk("post_rst_irq", 9'(interrupt), 9'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
